wb_ram_responder: RTL and testbench
===================================

# wb_ram_responder

Wishbone B4 responder that terminates ZAP CPU bus cycles for a local word-organised RAM window (BIOS shadow / DRAM stand-in in simulation and on FPGA). It is the target end of the CPU's Wishbone initiator port: it decodes the window, inserts programmable wait states, commits byte-lane writes, returns read data and supports incrementing and wrapping bursts. It sits beside the MADAM/CLIO register decode and drives the default read-data leg of the CPU data mux.

## Interface
- BASE_ADDR, 32'h0000_0000, byte base address of the window (aligned to window size)
- ADDR_W, 12, word-address width; window is 2^ADDR_W 32-bit words
- WAIT_STATES, 1, extra cycles before the first ack of a cycle (0..15)

- sys_clk  in  1  single clock; everything is on its rising edge
- reset  in  1  asynchronous, active-high
- i_wb_cyc  in  1  cycle valid
- i_wb_stb  in  1  strobe
- i_wb_we  in  1  1 = write
- i_wb_adr  in  32  byte address; [1:0] ignored
- i_wb_dat  in  32  write data
- i_wb_sel  in  4  byte lanes, bit n = i_wb_dat[8n+7:8n]
- i_wb_cti  in  3  000 classic, 010 incrementing burst, 111 end-of-burst
- i_wb_bte  in  2  00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16
- o_wb_dat  out  32  read data, valid while o_wb_ack = 1
- o_wb_ack  out  1  normal termination
- o_wb_err  out  1  error termination (address outside window)

## Operation
- Hit = i_wb_adr in [BASE_ADDR, BASE_ADDR + 4*2^ADDR_W); word index = i_wb_adr[ADDR_W+1:2].
- States: IDLE, WAIT, ACK, BURST.
- IDLE: on edge with cyc & stb & hit, load wait counter with WAIT_STATES, go WAIT (or ACK directly if WAIT_STATES = 0). cyc & stb & !hit: o_wb_err = 1 for exactly one cycle, no memory access, stay IDLE.
- WAIT: decrement counter each edge; at 0 go ACK. If cyc drops, go IDLE, no access.
- ACK: o_wb_ack = 1 for one cycle. Write: bytes with sel = 1 written on the edge that raises ack; sel = 0 lanes unchanged. Read: o_wb_dat = mem[index] while ack high.
- After ACK: if cti = 010 and burst support compiled in, go BURST; else IDLE (ack low at least one cycle before next classic ack).
- BURST: next index = index + 1 (linear) or wraps within aligned 4/8/16-word block per bte (low 2/3/4 bits increment, upper bits fixed). Ack asserted every cycle in which stb = 1 and i_wb_adr matches the predicted next address; no wait states after the first beat. stb = 0 with cyc = 1: ack low, hold state and predicted address. Address mismatch: ack low, go IDLE, request re-decoded as a new cycle next edge. Beat with cti = 111 acked, then IDLE. cyc = 0 at any time: IDLE.
- o_wb_ack and o_wb_err are never high together; neither is high unless cyc & stb.

## Timing
- Reset: o_wb_ack = 0, o_wb_err = 0, o_wb_dat = 0, state IDLE, counter 0; RAM contents not cleared. Reset mid-cycle drops ack immediately; a write not yet acked is never committed.
- First-beat latency: ack high in cycle WAIT_STATES+1 after the edge that samples cyc & stb (WAIT_STATES = 0: ack in the cycle directly after the request edge).
- Error latency: o_wb_err high in the cycle directly after the request edge.
- Burst throughput: one beat per cycle after the first; read data for beat k+1 fetched using predicted address so it is valid with its ack.
- Linear burst reaching the top word of the window: next predicted index wraps to 0; the initiator's address then mismatches and the burst terminates per mismatch rule.

## Configuration
- WB_RESP_BURST_EN defined: BURST state and bte wrap logic present as above.
- Not defined: cti and bte ignored; every beat, including burst beats, runs as a classic cycle with full WAIT_STATES and an ack-low cycle between beats.

## Test plan
- WAIT_STATES = 2, classic read of word 5 preloaded 32'hDEAD_BEEF -> ack high exactly in 3rd cycle after request, o_wb_dat = 32'hDEAD_BEEF, ack one cycle only.
- Write 32'h1122_3344, sel = 4'b0101, over 32'hAAAA_AAAA -> readback 32'hAA22_AA44.
- Access BASE_ADDR + 4*2^ADDR_W -> o_wb_err one cycle, ack never high, RAM unchanged.
- Burst read wrap-4 starting word 6 (cti 010 x3, 111 last) -> indices 6,7,4,5, acks consecutive after first beat; without WB_RESP_BURST_EN each beat pays WAIT_STATES.
- Burst with stb low for 2 cycles mid-burst, then resumed -> ack low during gap, sequence continues at predicted address.
- Assert reset during WAIT of a write -> ack low immediately, target word unchanged, next request served normally.

Source files
------------

// File: rtl/wb_ram_responder_if.sv
// wb_ram_responder_if: Wishbone B4 bus between the CPU initiator and the RAM window responder.
interface wb_ram_responder_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic [2:0]  i_wb_cti;
    logic [1:0]  i_wb_bte;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack;
    logic        o_wb_err;
    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel, i_wb_cti, i_wb_bte,
        input  o_wb_dat, o_wb_ack, o_wb_err
    );
    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_adr, i_wb_dat, i_wb_sel, i_wb_cti, i_wb_bte,
        output o_wb_dat, o_wb_ack, o_wb_err
    );
endinterface

// File: rtl/wb_ram_responder.sv
// wb_ram_responder: Wishbone B4 RAM window responder with wait states and byte-lane writes.
// Define WB_RESP_BURST_EN to add incrementing/wrapping burst support.
module wb_ram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_STATES = 1
) (
    input logic               sys_clk,
    input logic               reset,
    wb_ram_responder_if.slave wb
);
    typedef enum logic [1:0] {IDLE, WAIT, ACK, BURST} state_t;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [31:0]       dat_q, dat_d;
    logic              err_q, err_d;
    logic [31:0]       mem [2**ADDR_W];
    logic              req, hit, match, wr_en, unused;
    logic [ADDR_W-1:0] adr_idx, nxt_idx, wr_idx, mask;

    assign req     = wb.i_wb_cyc && wb.i_wb_stb;
    assign hit     = wb.i_wb_adr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2];
    assign adr_idx = wb.i_wb_adr[ADDR_W+1:2];
    assign match   = hit && adr_idx == idx_q;
    assign unused  = ^{wb.i_wb_adr[1:0], wb.i_wb_bte};

`ifdef WB_RESP_BURST_EN
    localparam bit BURST_EN = 1'b1;
    assign mask = wb.i_wb_bte == 2'b01 ? ADDR_W'(4'h3) :
                  wb.i_wb_bte == 2'b10 ? ADDR_W'(4'h7) :
                  wb.i_wb_bte == 2'b11 ? ADDR_W'(4'hF) : '1;
`else
    localparam bit BURST_EN = 1'b0;
    assign mask = '1;
`endif
    // Wrapping bursts only advance the low bits inside the aligned block.
    assign nxt_idx = (idx_q & ~mask) | ((idx_q + 1'b1) & mask);

    always_ff @(posedge sys_clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
        end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (req && !err_q) begin
                err_d   = !hit;
                idx_d   = adr_idx;
                cnt_d   = 4'(WAIT_STATES);
                state_d = !hit ? IDLE : WAIT_STATES == 0 ? ACK : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = !wb.i_wb_cyc ? IDLE : cnt_q <= 4'd1 ? ACK : WAIT;
            end
            ACK: state_d = BURST_EN && req && wb.i_wb_cti == 3'b010 ? BURST : IDLE;
            default: state_d = !wb.i_wb_cyc || (wb.i_wb_stb && (!match || wb.i_wb_cti != 3'b010)) ? IDLE : BURST;
        endcase
        if (state_d == BURST && (state_q == ACK || wb.i_wb_stb)) idx_d = nxt_idx;
        // Prefetch so burst read data is already valid with the next beat's ack.
        dat_d  = mem[idx_d];
        wr_en  = !reset && req && wb.i_wb_we && (state_d == ACK || (state_q == BURST && match));
        wr_idx = state_q == BURST ? idx_q : idx_d;
    end

    always_ff @(posedge sys_clk)
        if (wr_en)
            for (int b = 0; b < 4; b++)
                if (wb.i_wb_sel[b]) mem[wr_idx][8*b +: 8] <= wb.i_wb_dat[8*b +: 8];

    always_comb begin
        wb.o_wb_ack = req && (state_q == ACK || (state_q == BURST && match));
        wb.o_wb_err = req && err_q;
        wb.o_wb_dat = dat_q;
    end
endmodule

// File: tb/tb_wb_ram_responder.sv
// tb_wb_ram_responder: directed stimulus with a scoreboard queue checked by an independent ack/err monitor.
module tb_wb_ram_responder;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int AW = 12;
    localparam int WS = 2;
`ifdef WB_RESP_BURST_EN
    localparam int BEAT_GAP = 1;
`else
    localparam int BEAT_GAP = WS + 2;
`endif
    typedef struct packed {logic err; logic chk; logic [31:0] dat;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_ram_responder_if wb();
    wb_ram_responder #(.BASE_ADDR(BASE), .ADDR_W(AW), .WAIT_STATES(WS)) dut (
        .sys_clk(clk), .reset(rst), .wb(wb)
    );

    int n_chk = 0, n_fail = 0, cyc_n = 0;
    exp_t exp_q[$];
    logic [31:0] model [0:4095];
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic err, input logic chk, input logic [31:0] dat);
        exp_t e;
        e.err = err;
        e.chk = chk;
        e.dat = dat;
        exp_q.push_back(e);
    endtask

    // Monitor: every termination the DUT presents must match the next expected entry.
    always @(negedge clk) if (!rst && (wb.o_wb_ack || wb.o_wb_err)) begin
        exp_t e;
        check("ack/err exclusive", 32'(wb.o_wb_ack && wb.o_wb_err), 0);
        if (exp_q.size() == 0) check("unexpected termination", 32'({wb.o_wb_ack, wb.o_wb_err}), 0);
        else begin
            e = exp_q.pop_front();
            check("termination kind err", 32'(wb.o_wb_err), 32'(e.err));
            if (e.chk) check("read data", wb.o_wb_dat, e.dat);
        end
    end

    task automatic bus_idle();
        wb.i_wb_cyc = 0; wb.i_wb_stb = 0; wb.i_wb_we = 0; wb.i_wb_adr = '0;
        wb.i_wb_dat = '0; wb.i_wb_sel = '0; wb.i_wb_cti = '0; wb.i_wb_bte = '0;
    endtask

    task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [2:0] cti, input logic [1:0] bte);
        wb.i_wb_cyc = 1; wb.i_wb_stb = 1; wb.i_wb_we = we; wb.i_wb_adr = adr;
        wb.i_wb_dat = dat; wb.i_wb_sel = sel; wb.i_wb_cti = cti; wb.i_wb_bte = bte;
    endtask

    task automatic wait_term(input string name, output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wb.o_wb_ack || wb.o_wb_err) begin
                at = cyc_n;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL %s: no ack/err within 40 cycles, required a termination", name);
    endtask

    // Classic cycle; stb is held one cycle past the termination to prove it lasts a single cycle.
    task automatic classic(input string name, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic err, input logic [31:0] rd, input int lat);
        int t0, at;
        push(err, !we && !err, rd);
        @(posedge clk); #1;
        drive(we, adr, dat, sel, 3'b000, 2'b00);
        t0 = cyc_n;
        wait_term(name, at);
        if (at >= 0) check({name, " latency"}, 32'(at - t0), 32'(lat));
        @(negedge clk);
        check({name, " one-cycle term"}, 32'({wb.o_wb_ack, wb.o_wb_err}), 0);
        @(posedge clk); #1;
        bus_idle();
    endtask

    function automatic int nxt(input int i, input logic [1:0] b);
        int sz;
        sz = b == 2'b01 ? 4 : b == 2'b10 ? 8 : b == 2'b11 ? 16 : 4096;
        return (i / sz) * sz + (i + 1) % sz;
    endfunction

    task automatic burst(input string name, input int start, input logic [1:0] bte, input int n,
                         input int gap_at, input int gap_len);
        int at, prev, idx;
        idx = start;
        prev = 0;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            push(1'b0, 1'b1, model[idx]);
            drive(1'b0, BASE + 32'(idx * 4), '0, 4'hF, i == n - 1 ? 3'b111 : 3'b010, bte);
            wait_term(name, at);
            if (at < 0) break;
            if (i > 0) check({name, " beat spacing"}, 32'(at - prev), 32'((i == gap_at ? gap_len : 0) + BEAT_GAP));
            prev = at;
            idx = nxt(idx, bte);
            @(posedge clk); #1;
            if (i + 1 == gap_at) begin
                wb.i_wb_stb = 0;
                repeat (gap_len) begin
                    @(negedge clk);
                    check({name, " ack low in gap"}, 32'(wb.o_wb_ack), 0);
                end
                @(posedge clk); #1;
            end
        end
        bus_idle();
    endtask

    int at;
    int pre_idx [11] = '{0, 4, 5, 6, 7, 9, 10, 16, 17, 18, 19};
    logic [31:0] pre_val [11] = '{32'h0BAD_F00D, 32'h4040_4040, 32'hDEAD_BEEF, 32'h6060_6060, 32'h7070_7070,
                                  32'h5555_5555, 32'hAAAA_AAAA, 32'h1600_0016, 32'h1700_0017, 32'h1800_0018,
                                  32'h1900_0019};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus_idle();
        @(negedge clk);
        check("reset ack", 32'(wb.o_wb_ack), 0);
        check("reset err", 32'(wb.o_wb_err), 0);
        check("reset dat", wb.o_wb_dat, 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 11; i++) begin
            model[pre_idx[i]] = pre_val[i];
            classic("preload write", 1'b1, BASE + 32'(pre_idx[i] * 4), pre_val[i], 4'hF, 1'b0, '0, WS + 1);
        end

        classic("read word5", 1'b0, BASE + 32'd20, '0, 4'hF, 1'b0, 32'hDEAD_BEEF, WS + 1);

        classic("lane write", 1'b1, BASE + 32'd40, 32'h1122_3344, 4'b0101, 1'b0, '0, WS + 1);
        classic("lane readback", 1'b0, BASE + 32'd40, '0, 4'hF, 1'b0, 32'hAA22_AA44, WS + 1);

        classic("err above window", 1'b1, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF, 1'b1, '0, 1);
        classic("err below window", 1'b0, BASE - 32'd4, '0, 4'hF, 1'b1, '0, 1);
        classic("ram intact after err", 1'b0, BASE, '0, 4'hF, 1'b0, 32'h0BAD_F00D, WS + 1);

        burst("wrap4 burst", 6, 2'b01, 4, -1, 0);
        burst("linear gap burst", 16, 2'b00, 4, 2, 2);

        @(posedge clk); #1;
        drive(1'b1, BASE + 32'd36, 32'h1234_5678, 4'hF, 3'b000, 2'b00);
        @(posedge clk);
        @(negedge clk);
        rst = 1; #1;
        check("reset in wait ack", 32'(wb.o_wb_ack), 0);
        bus_idle();
        @(negedge clk);
        check("reset in wait dat", wb.o_wb_dat, 0);
        rst = 0;
        classic("write dropped by reset", 1'b0, BASE + 32'd36, '0, 4'hF, 1'b0, 32'h5555_5555, WS + 1);

        push(1'b0, 1'b1, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        drive(1'b0, BASE + 32'd20, '0, 4'hF, 3'b000, 2'b00);
        wait_term("reset during ack", at);
        #1; rst = 1; #1;
        check("reset drops ack", 32'(wb.o_wb_ack), 0);
        check("reset clears dat", wb.o_wb_dat, 0);
        bus_idle();
        @(negedge clk);
        rst = 0;
        classic("read after reset", 1'b0, BASE + 32'd40, '0, 4'hF, 1'b0, 32'hAA22_AA44, WS + 1);

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
